sha256_round_engine: RTL and testbench

- Iterative SHA-256 compression core that consumes one 512-bit block and a 256-bit chaining digest, running 64 rounds at one round per cycle.
- Sits directly downstream of the K-constant ROM. It drives `k_addr` with the current round index and consumes the returned 32-bit `k_in` in the same cycle; the ROM lookup is combinational.
- Contains the 16-word sliding message-schedule window, the a..h working registers and the final digest addition.

---
 rtl/sha256_round_engine_if.sv | 22 ++
 rtl/sha256_round_engine.sv | 97 +++++++++
 tb/tb_sha256_round_engine.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sha256_round_engine_if.sv
// sha256_round_engine_if: host and K-ROM signal bundle for the SHA-256 round engine.
// The abort signal exists only when SHA256_ENGINE_ABORT_EN is defined.
interface sha256_round_engine_if;
    logic         init;
`ifdef SHA256_ENGINE_ABORT_EN
    logic         abort;
`endif
    logic [511:0] block;
    logic [255:0] digest_in;
    logic         ready;
    logic         digest_valid;
    logic [255:0] digest_out;
    logic [5:0]   k_addr;
    logic [31:0]  k_in;
`ifdef SHA256_ENGINE_ABORT_EN
    modport master (output init, abort, block, digest_in, k_in, input ready, digest_valid, digest_out, k_addr);
    modport slave (input init, abort, block, digest_in, k_in, output ready, digest_valid, digest_out, k_addr);
`else
    modport master (output init, block, digest_in, k_in, input ready, digest_valid, digest_out, k_addr);
    modport slave (input init, block, digest_in, k_in, output ready, digest_valid, digest_out, k_addr);
`endif
endinterface

// File: rtl/sha256_round_engine.sv
// sha256_round_engine: iterative SHA-256 compression, one round per cycle, 65 edges init to digest.
// Define SHA256_ENGINE_ABORT_EN to add the abort input that cancels an in-flight block.
module sha256_round_engine (
    input logic            clk,
    input logic            reset,
    sha256_round_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUNDS, FINAL} state_e;
    state_e       state_q, state_d;
    logic [5:0]   t_q, t_d;
    logic [31:0]  h_q [8], h_d [8];
    logic [31:0]  wk_q [8], wk_d [8];
    logic [31:0]  w_q [16], w_d [16];
    logic [255:0] dig_q, dig_d;
    logic         vld_q, vld_d;
    logic [31:0]  t1, t2, w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // wk_q[0..7] hold a..h
    assign t1 = wk_q[7] + (rotr(wk_q[4], 6) ^ rotr(wk_q[4], 11) ^ rotr(wk_q[4], 25))
              + ((wk_q[4] & wk_q[5]) ^ (~wk_q[4] & wk_q[6])) + bus.k_in + w_q[0];
    assign t2 = (rotr(wk_q[0], 2) ^ rotr(wk_q[0], 13) ^ rotr(wk_q[0], 22))
              + ((wk_q[0] & wk_q[1]) ^ (wk_q[0] & wk_q[2]) ^ (wk_q[1] & wk_q[2]));
    assign w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
                 + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];

    assign bus.ready        = state_q == IDLE;
    assign bus.digest_valid = vld_q;
    assign bus.digest_out   = dig_q;
    assign bus.k_addr       = t_q;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        h_d     = h_q;
        wk_d    = wk_q;
        w_d     = w_q;
        dig_d   = dig_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: if (bus.init) begin
                for (int i = 0; i < 8; i++) begin
                    h_d[i]  = bus.digest_in[255-32*i -: 32];
                    wk_d[i] = bus.digest_in[255-32*i -: 32];
                end
                for (int i = 0; i < 16; i++) w_d[i] = bus.block[511-32*i -: 32];
                t_d     = '0;
                vld_d   = 1'b0;
                state_d = ROUNDS;
            end
            ROUNDS: begin
                wk_d = '{t1 + t2, wk_q[0], wk_q[1], wk_q[2], wk_q[3] + t1, wk_q[4], wk_q[5], wk_q[6]};
                for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
                w_d[15] = w_new;
                t_d     = t_q + 6'd1;
                state_d = t_q == 6'd63 ? FINAL : ROUNDS;
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) dig_d[255-32*i -: 32] = h_q[i] + wk_q[i];
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef SHA256_ENGINE_ABORT_EN
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            t_d     = '0;
            dig_d   = dig_q;
            vld_d   = vld_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            dig_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            dig_q   <= dig_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        h_q  <= h_d;
        wk_q <= wk_d;
        w_q  <= w_d;
    end
endmodule

// File: tb/tb_sha256_round_engine.sv
// tb_sha256_round_engine: directed SHA-256 vectors against the round engine with a combinational K ROM.
// Define SHA256_ENGINE_ABORT_EN to also exercise the abort path.
module tb_sha256_round_engine;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    logic [255:0] dig;

    sha256_round_engine_if bus ();
    sha256_round_engine dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    assign bus.k_in = K[bus.k_addr];

    localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] ABC     = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2  = {448'h0, 64'h1c0};
    localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept edge is E0; afterwards the inputs are scrambled to prove they were sampled only once.
    task automatic start(input logic [511:0] b, input logic [255:0] d);
        bus.block     = b;
        bus.digest_in = d;
        bus.init      = 1'b1;
        tick();
        bus.init      = 1'b0;
        bus.block     = ~b;
        bus.digest_in = ~d;
    endtask

    task automatic finish_run(input int n0, input bit chk_k, output logic [255:0] d);
        int n = n0;
        bit rdy_bad = 1'b0;
        while (!bus.digest_valid && n < 200) begin
            if (bus.ready) rdy_bad = 1'b1;
            if (chk_k && n < 64) chk("k_addr", {250'h0, bus.k_addr}, n);
            tick();
            n++;
        end
        chk("latency", n, 65);
        chk("ready_low_during_run", {255'h0, rdy_bad}, 0);
        d = bus.digest_out;
    endtask

    initial begin
        reset         = 1'b1;
        bus.init      = 1'b0;
`ifdef SHA256_ENGINE_ABORT_EN
        bus.abort     = 1'b0;
`endif
        bus.block     = '0;
        bus.digest_in = '0;
        tick();
        tick();
        chk("rst_ready", {255'h0, bus.ready}, 1);
        chk("rst_valid", {255'h0, bus.digest_valid}, 0);
        chk("rst_digest", bus.digest_out, 0);
        chk("rst_k_addr", {250'h0, bus.k_addr}, 0);
        reset = 1'b0;
        tick();

        start(ABC, IV);
        finish_run(0, 1'b1, dig);
        chk("abc_digest", dig, ABC_DIG);
        chk("abc_ready", {255'h0, bus.ready}, 1);
        chk("idle_k_addr", {250'h0, bus.k_addr}, 0);
        repeat (3) tick();
        chk("valid_held", {255'h0, bus.digest_valid}, 1);
        chk("digest_held", bus.digest_out, ABC_DIG);

        start(TWO_B1, IV);
        chk("valid_cleared_on_init", {255'h0, bus.digest_valid}, 0);
        finish_run(0, 1'b0, dig);
        start(TWO_B2, dig);
        finish_run(0, 1'b0, dig);
        chk("two_block_digest", dig, TWO_DIG);

        start(ABC, IV);
        repeat (20) tick();
        chk("k_addr_round20", {250'h0, bus.k_addr}, 20);
        bus.block     = TWO_B1;
        bus.digest_in = ~IV;
        bus.init      = 1'b1;
        tick();
        bus.init      = 1'b0;
        finish_run(21, 1'b1, dig);
        chk("ignored_init_digest", dig, ABC_DIG);

        start(ABC, IV);
        repeat (64) tick();
        chk("final_ready", {255'h0, bus.ready}, 0);
        chk("final_valid", {255'h0, bus.digest_valid}, 0);
        bus.block     = TWO_B1;
        bus.init      = 1'b1;
        tick();
        bus.init      = 1'b0;
        chk("e65_valid", {255'h0, bus.digest_valid}, 1);
        chk("e65_digest", bus.digest_out, ABC_DIG);
        tick();
        chk("init_at_valid_rise_ignored", {255'h0, bus.ready}, 1);
        chk("init_at_valid_rise_valid", {255'h0, bus.digest_valid}, 1);

        start(TWO_B1, IV);
        repeat (30) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrun_rst_ready", {255'h0, bus.ready}, 1);
        chk("midrun_rst_valid", {255'h0, bus.digest_valid}, 0);
        chk("midrun_rst_digest", bus.digest_out, 0);
        chk("midrun_rst_k_addr", {250'h0, bus.k_addr}, 0);
        start(ABC, IV);
        finish_run(0, 1'b1, dig);
        chk("post_rst_digest", dig, ABC_DIG);

`ifdef SHA256_ENGINE_ABORT_EN
        bus.abort = 1'b1;
        tick();
        chk("idle_abort_noop", {255'h0, bus.digest_valid}, 1);
        bus.abort = 1'b0;
        start(TWO_B1, IV);
        repeat (10) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_ready", {255'h0, bus.ready}, 1);
        chk("abort_valid", {255'h0, bus.digest_valid}, 0);
        chk("abort_digest_kept", bus.digest_out, ABC_DIG);
        chk("abort_k_addr", {250'h0, bus.k_addr}, 0);
        start(ABC, IV);
        finish_run(0, 1'b1, dig);
        chk("post_abort_digest", dig, ABC_DIG);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
